mem_resp_model: RTL and testbench

MEM_RESP_MODEL -- requirements
Module: mem_resp_model

---
 rtl/mem_resp_model.sv | 192 +++++++++++++++++++
 tb/tb_mem_resp_model.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_resp_model.sv
// Multi-port behavioural memory: per-port request FSMs, round-robin serialized access, fixed response latency.
// Optional MEM_MODEL_UART_EN decodes a minimal UART register block at UART_BASE.
module mem_resp_model #(
    parameter int          NPORTS     = 2,
    parameter logic [31:0] MEM_BASE   = 32'h3000_0000,
    parameter int unsigned MEM_SIZE_B = 16777216,
    parameter int          LATENCY    = 0,
    parameter logic [31:0] UART_BASE  = 32'h1000_0000,
    parameter string       INIT_FILE  = ""
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NPORTS-1:0]     req_valid,
    output logic [NPORTS-1:0]     req_ready,
    input  logic [32*NPORTS-1:0]  req_addr,
    input  logic [NPORTS-1:0]     req_wen,
    input  logic [32*NPORTS-1:0]  req_wdata,
    input  logic [4*NPORTS-1:0]   req_wmask,
    output logic [NPORTS-1:0]     resp_valid,
    output logic [32*NPORTS-1:0]  resp_rdata,
    output logic [NPORTS-1:0]     resp_err
);

    // state | meaning
    // IDLE  | ready, waiting for req_valid
    // WAIT  | request captured, waiting for round-robin grant
    // DELAY | access done, counting out LATENCY cycles
    // RESP  | one-cycle response on resp_*
    typedef enum logic [1:0] {IDLE, WAIT, DELAY, RESP} state_t;

    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int AW = $clog2(MEM_SIZE_B);
`ifdef MEM_MODEL_UART_EN
    localparam bit UART_EN = 1'b1;
`else
    localparam bit UART_EN = 1'b0;
`endif

    state_t        state_q   [NPORTS];
    state_t        state_d   [NPORTS];
    logic [3:0]    dly_q     [NPORTS];
    logic [31:0]   cap_addr  [NPORTS];
    logic          cap_wen   [NPORTS];
    logic [31:0]   cap_wdata [NPORTS];
    logic [3:0]    cap_wmask [NPORTS];
    logic [31:0]   res_rdata [NPORTS];
    logic          res_err   [NPORTS];

    logic [PW-1:0] last_grant;
    logic [PW-1:0] grant_idx;
    logic          grant_vld;

    logic [7:0]    mem [MEM_SIZE_B];

    logic [31:0]   g_addr;
    logic [31:0]   g_wdata;
    logic [3:0]    g_wmask;
    logic          g_wen;
    logic [31:0]   offs;
    logic [AW-3:0] word_idx;
    logic          mem_hit;
    logic          uart_hit;
    logic [31:0]   acc_rdata;
    logic          acc_err;

    function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base, input int step);
        return PW'((int'(base) + 1 + step) % NPORTS);
    endfunction

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (!grant_vld && state_q[rr_index(last_grant, i)] == WAIT) begin
                grant_vld = 1'b1;
                grant_idx = rr_index(last_grant, i);
            end
        end
    end

    // Address decode for the granted port; offset below MEM_BASE wraps high and fails the range test.
    always_comb begin
        g_addr   = cap_addr[grant_idx];
        g_wdata  = cap_wdata[grant_idx];
        g_wmask  = cap_wmask[grant_idx];
        g_wen    = cap_wen[grant_idx];
        offs     = {g_addr[31:2], 2'b00} - MEM_BASE;
        word_idx = offs[AW-1:2];
        mem_hit  = (offs < 32'(MEM_SIZE_B));
        uart_hit = 1'b0;
        if (UART_EN) begin
            if (g_wen)
                uart_hit = (g_addr == UART_BASE) || (g_addr == UART_BASE + 32'd1) ||
                           (g_addr == UART_BASE + 32'd3);
            else
                uart_hit = (g_addr == UART_BASE + 32'd5);
        end
        acc_err   = 1'b0;
        acc_rdata = 32'h0;
        if (uart_hit) begin
            acc_rdata = g_wen ? 32'h0 : 32'h2020_2020;
        end else if (mem_hit) begin
            if (!g_wen)
                acc_rdata = {mem[{word_idx, 2'd3}], mem[{word_idx, 2'd2}],
                             mem[{word_idx, 2'd1}], mem[{word_idx, 2'd0}]};
        end else begin
            acc_err   = 1'b1;
            acc_rdata = 32'hdead_beef;
        end
    end

    // Storage is never reset.
    always_ff @(posedge clock) begin
        if (!reset && grant_vld && g_wen && mem_hit && !uart_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (g_wmask[b])
                    mem[{word_idx, 2'(b)}] <= g_wdata[8*b +: 8];
            end
        end
    end

`ifdef MEM_MODEL_UART_EN
    always_ff @(posedge clock) begin
        if (!reset && grant_vld && g_wen && uart_hit && g_addr == UART_BASE)
            $write("%c", g_wdata[7:0]);
    end
`endif

    always_comb begin
        for (int p = 0; p < NPORTS; p++) begin
            state_d[p] = state_q[p];
            case (state_q[p])
                IDLE:    if (req_valid[p]) state_d[p] = WAIT;
                WAIT:    if (grant_vld && grant_idx == PW'(p))
                             state_d[p] = (LATENCY == 0) ? RESP : DELAY;
                DELAY:   if (dly_q[p] <= 4'd1) state_d[p] = RESP;
                RESP:    state_d[p] = IDLE;
                default: state_d[p] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant <= PW'(NPORTS - 1);
            for (int p = 0; p < NPORTS; p++) begin
                state_q[p]   <= IDLE;
                dly_q[p]     <= 4'd0;
                cap_addr[p]  <= 32'h0;
                cap_wen[p]   <= 1'b0;
                cap_wdata[p] <= 32'h0;
                cap_wmask[p] <= 4'h0;
                res_rdata[p] <= 32'h0;
                res_err[p]   <= 1'b0;
            end
        end else begin
            for (int p = 0; p < NPORTS; p++) begin
                state_q[p] <= state_d[p];
                if (state_q[p] == IDLE && req_valid[p]) begin
                    cap_addr[p]  <= req_addr[32*p +: 32];
                    cap_wen[p]   <= req_wen[p];
                    cap_wdata[p] <= req_wdata[32*p +: 32];
                    cap_wmask[p] <= req_wmask[4*p +: 4];
                end
                if (state_q[p] == DELAY)
                    dly_q[p] <= dly_q[p] - 4'd1;
            end
            if (grant_vld) begin
                last_grant           <= grant_idx;
                dly_q[grant_idx]     <= 4'(LATENCY);
                res_rdata[grant_idx] <= acc_rdata;
                res_err[grant_idx]   <= acc_err;
            end
        end
    end

    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        resp_rdata = '0;
        resp_err   = '0;
        for (int p = 0; p < NPORTS; p++) begin
            req_ready[p] = (state_q[p] == IDLE);
            if (state_q[p] == RESP) begin
                resp_valid[p]          = 1'b1;
                resp_rdata[32*p +: 32] = res_rdata[p];
                resp_err[p]            = res_err[p];
            end
        end
    end

endmodule

// File: tb/tb_mem_resp_model.sv
// Directed bench for mem_resp_model: four instances cover latency 0/3/5, two and four ports, reset corners.
module tb_mem_resp_model;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

`ifdef MEM_MODEL_UART_EN
    localparam bit UART = 1'b1;
`else
    localparam bit UART = 1'b0;
`endif

    logic [1:0]   a_req_valid, a_req_ready, a_req_wen, a_resp_valid, a_resp_err;
    logic [63:0]  a_req_addr, a_req_wdata, a_resp_rdata;
    logic [7:0]   a_req_wmask;
    logic [1:0]   b_req_valid, b_req_ready, b_req_wen, b_resp_valid, b_resp_err;
    logic [63:0]  b_req_addr, b_req_wdata, b_resp_rdata;
    logic [7:0]   b_req_wmask;
    logic [3:0]   c_req_valid, c_req_ready, c_req_wen, c_resp_valid, c_resp_err;
    logic [127:0] c_req_addr, c_req_wdata, c_resp_rdata;
    logic [15:0]  c_req_wmask;
    logic [0:0]   d_req_valid, d_req_ready, d_req_wen, d_resp_valid, d_resp_err;
    logic [31:0]  d_req_addr, d_req_wdata, d_resp_rdata;
    logic [3:0]   d_req_wmask;

    mem_resp_model #(.NPORTS(2), .LATENCY(0)) u_a (
        .clock(clock), .reset(reset), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_addr(a_req_addr), .req_wen(a_req_wen), .req_wdata(a_req_wdata), .req_wmask(a_req_wmask),
        .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata), .resp_err(a_resp_err));
    mem_resp_model #(.NPORTS(2), .LATENCY(3), .MEM_SIZE_B(4096)) u_b (
        .clock(clock), .reset(reset), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_addr(b_req_addr), .req_wen(b_req_wen), .req_wdata(b_req_wdata), .req_wmask(b_req_wmask),
        .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .resp_err(b_resp_err));
    mem_resp_model #(.NPORTS(4), .LATENCY(0), .MEM_SIZE_B(4096)) u_c (
        .clock(clock), .reset(reset), .req_valid(c_req_valid), .req_ready(c_req_ready),
        .req_addr(c_req_addr), .req_wen(c_req_wen), .req_wdata(c_req_wdata), .req_wmask(c_req_wmask),
        .resp_valid(c_resp_valid), .resp_rdata(c_resp_rdata), .resp_err(c_resp_err));
    mem_resp_model #(.NPORTS(1), .LATENCY(5), .MEM_SIZE_B(4096)) u_d (
        .clock(clock), .reset(reset), .req_valid(d_req_valid), .req_ready(d_req_ready),
        .req_addr(d_req_addr), .req_wen(d_req_wen), .req_wdata(d_req_wdata), .req_wmask(d_req_wmask),
        .resp_valid(d_resp_valid), .resp_rdata(d_resp_rdata), .resp_err(d_resp_err));

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic drive(input int inst, input int p, input logic v, input logic w,
                         input logic [31:0] ad, input logic [31:0] wd, input logic [3:0] m);
        case (inst)
            0: begin a_req_valid[p] = v; a_req_wen[p] = w; a_req_addr[32*p +: 32] = ad;
                     a_req_wdata[32*p +: 32] = wd; a_req_wmask[4*p +: 4] = m; end
            1: begin b_req_valid[p] = v; b_req_wen[p] = w; b_req_addr[32*p +: 32] = ad;
                     b_req_wdata[32*p +: 32] = wd; b_req_wmask[4*p +: 4] = m; end
            2: begin c_req_valid[p] = v; c_req_wen[p] = w; c_req_addr[32*p +: 32] = ad;
                     c_req_wdata[32*p +: 32] = wd; c_req_wmask[4*p +: 4] = m; end
            default: begin d_req_valid[p] = v; d_req_wen[p] = w; d_req_addr = ad;
                     d_req_wdata = wd; d_req_wmask = m; end
        endcase
    endtask

    function automatic logic rdy(input int inst, input int p);
        case (inst)
            0: rdy = a_req_ready[p];
            1: rdy = b_req_ready[p];
            2: rdy = c_req_ready[p];
            default: rdy = d_req_ready[p];
        endcase
    endfunction

    function automatic logic rv(input int inst, input int p);
        case (inst)
            0: rv = a_resp_valid[p];
            1: rv = b_resp_valid[p];
            2: rv = c_resp_valid[p];
            default: rv = d_resp_valid[p];
        endcase
    endfunction

    function automatic logic [31:0] rd(input int inst, input int p);
        case (inst)
            0: rd = a_resp_rdata[32*p +: 32];
            1: rd = b_resp_rdata[32*p +: 32];
            2: rd = c_resp_rdata[32*p +: 32];
            default: rd = d_resp_rdata;
        endcase
    endfunction

    function automatic logic re(input int inst, input int p);
        case (inst)
            0: re = a_resp_err[p];
            1: re = b_resp_err[p];
            2: re = c_resp_err[p];
            default: re = d_resp_err[p];
        endcase
    endfunction

    // Single uncontended access; lat counts edges after the accepting edge until resp_valid is seen.
    task automatic do_access(input int inst, input int p, input logic w, input logic [31:0] ad,
                             input logic [31:0] wd, input logic [3:0] m, input int exp_lat,
                             input logic [31:0] exp_rd, input logic exp_err, input string name);
        int lat;
        logic [31:0] got_rd;
        logic got_err;
        lat = -1;
        got_rd = 32'h0;
        got_err = 1'b0;
        @(posedge clock); #1;
        chk({name, " ready"}, 32'(rdy(inst, p)), 32'd1);
        drive(inst, p, 1'b1, w, ad, wd, m);
        @(posedge clock); #1;
        drive(inst, p, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        for (int k = 0; k <= 30; k++) begin
            if (k > 0) begin @(posedge clock); #1; end
            if (rv(inst, p)) begin
                lat = k; got_rd = rd(inst, p); got_err = re(inst, p);
                break;
            end
        end
        chk({name, " latency"}, 32'(lat), 32'(exp_lat));
        chk({name, " rdata"}, got_rd, exp_rd);
        chk({name, " err"}, 32'(got_err), 32'(exp_err));
        @(posedge clock); #1;
        chk({name, " pulse"}, 32'(rv(inst, p)), 32'd0);
    endtask

    int          c_first [4];
    int          c_cnt   [4];
    logic [31:0] c_data  [4];

    task automatic c_burst(input logic [3:0] mask, input logic [3:0] w, input logic [31:0] shared_addr);
        @(posedge clock); #1;
        for (int p = 0; p < 4; p++) begin
            c_first[p] = -1; c_cnt[p] = 0; c_data[p] = 32'h0;
            if (mask[p])
                drive(2, p, 1'b1, w[p], (shared_addr != 32'h0) ? shared_addr : 32'h3000_0100 + 32'(4*p),
                      32'h5A5A_5A5A, 4'hF);
        end
        @(posedge clock); #1;
        c_req_valid = '0;
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) begin @(posedge clock); #1; end
            for (int p = 0; p < 4; p++) begin
                if (c_resp_valid[p]) begin
                    c_cnt[p]++;
                    if (c_first[p] < 0) begin c_first[p] = k; c_data[p] = c_resp_rdata[32*p +: 32]; end
                end
            end
        end
    endtask

    task automatic c_expect(input int p, input int k, input logic [31:0] d, input string name);
        chk({name, " slot"}, 32'(c_first[p]), 32'(k));
        chk({name, " rdata"}, c_data[p], d);
        chk({name, " count"}, 32'(c_cnt[p]), 32'd1);
    endtask

    typedef struct {
        int          port;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] exp_rd;
        logic        exp_err;
        string       name;
    } vec_t;
    vec_t vecs [$];

    task automatic add_vec(input int p, input logic w, input logic [31:0] ad, input logic [31:0] wd,
                           input logic [3:0] m, input logic [31:0] er, input logic ee, input string n);
        vec_t v;
        v.port = p; v.wen = w; v.addr = ad; v.wdata = wd; v.wmask = m;
        v.exp_rd = er; v.exp_err = ee; v.name = n;
        vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] u_wr_rd, u_rd5;
        logic        u_err;
        u_wr_rd = UART ? 32'h0 : 32'hdead_beef;
        u_rd5   = UART ? 32'h2020_2020 : 32'hdead_beef;
        u_err   = !UART;

        a_req_valid = '0; a_req_wen = '0; a_req_addr = '0; a_req_wdata = '0; a_req_wmask = '0;
        b_req_valid = '0; b_req_wen = '0; b_req_addr = '0; b_req_wdata = '0; b_req_wmask = '0;
        c_req_valid = '0; c_req_wen = '0; c_req_addr = '0; c_req_wdata = '0; c_req_wmask = '0;
        d_req_valid = '0; d_req_wen = '0; d_req_addr = '0; d_req_wdata = '0; d_req_wmask = '0;

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        chk("rst a ready", 32'(a_req_ready), 32'h3);
        chk("rst a valid", 32'(a_resp_valid), 32'h0);
        chk("rst a rdata", 32'(|a_resp_rdata), 32'h0);
        chk("rst a err", 32'(a_resp_err), 32'h0);
        chk("rst b ready", 32'(b_req_ready), 32'h3);
        chk("rst c ready", 32'(c_req_ready), 32'hF);
        chk("rst c valid", 32'(c_resp_valid), 32'h0);
        chk("rst d ready", 32'(d_req_ready), 32'h1);

        add_vec(0, 1'b1, 32'h3000_0010, 32'hA5A5_1234, 4'b0011, 32'h0, 1'b0, "wr lo half");
        add_vec(0, 1'b0, 32'h3000_0010, 32'h0, 4'h0, 32'h0000_1234, 1'b0, "rd lo half");
        add_vec(1, 1'b1, 32'h3000_0010, 32'hFFEE_DDCC, 4'b1100, 32'h0, 1'b0, "wr hi half");
        add_vec(1, 1'b0, 32'h3000_0012, 32'h0, 4'h0, 32'hFFEE_1234, 1'b0, "rd unaligned");
        add_vec(0, 1'b1, 32'h3000_0010, 32'h0, 4'b0000, 32'h0, 1'b0, "wr no mask");
        add_vec(0, 1'b0, 32'h3000_0010, 32'h0, 4'h0, 32'hFFEE_1234, 1'b0, "rd after nomask");
        add_vec(0, 1'b0, 32'h2000_0000, 32'h0, 4'h0, 32'hdead_beef, 1'b1, "rd below base");
        add_vec(1, 1'b1, 32'h2000_0000, 32'h1234_5678, 4'hF, 32'hdead_beef, 1'b1, "wr below base");
        add_vec(1, 1'b1, 32'h3100_0010, 32'h0101_0101, 4'hF, 32'hdead_beef, 1'b1, "wr past end");
        add_vec(1, 1'b1, 32'h30FF_FFFC, 32'h1122_3344, 4'hF, 32'h0, 1'b0, "wr last word");
        add_vec(1, 1'b0, 32'h30FF_FFFF, 32'h0, 4'h0, 32'h1122_3344, 1'b0, "rd last word");
        add_vec(0, 1'b0, 32'h3100_0000, 32'h0, 4'h0, 32'hdead_beef, 1'b1, "rd end bound");
        add_vec(0, 1'b0, 32'h2FFF_FFFC, 32'h0, 4'h0, 32'hdead_beef, 1'b1, "rd just below");
        add_vec(1, 1'b1, 32'h1000_0000, 32'h0000_0041, 4'b0001, u_wr_rd, u_err, "uart tx");
        add_vec(0, 1'b0, 32'h1000_0005, 32'h0, 4'h0, u_rd5, u_err, "uart lsr");
        add_vec(0, 1'b1, 32'h1000_0003, 32'h0, 4'hF, u_wr_rd, u_err, "uart lcr");
        add_vec(0, 1'b0, 32'h3000_0010, 32'h0, 4'h0, 32'hFFEE_1234, 1'b0, "rd unchanged");

        foreach (vecs[i])
            do_access(0, vecs[i].port, vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].wmask,
                      1, vecs[i].exp_rd, vecs[i].exp_err, vecs[i].name);
        $display("");

        do_access(1, 1, 1'b1, 32'h3000_0000, 32'h0000_0513, 4'hF, 4, 32'h0, 1'b0, "lat3 wr");
        do_access(1, 1, 1'b0, 32'h3000_0000, 32'h0, 4'h0, 4, 32'h0000_0513, 1'b0, "lat3 rd p1");
        do_access(1, 0, 1'b0, 32'h3000_0000, 32'h0, 4'h0, 4, 32'h0000_0513, 1'b0, "lat3 rd p0");

        for (int i = 0; i < 4; i++)
            do_access(2, 0, 1'b1, 32'h3000_0100 + 32'(4*i), 32'hC0DE_0000 + 32'(i), 4'hF, 1,
                      32'h0, 1'b0, "c preload");
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        chk("c ready after reset", 32'(c_req_ready), 32'hF);

        c_burst(4'b1111, 4'b0000, 32'h0);
        for (int p = 0; p < 4; p++)
            c_expect(p, p + 1, 32'hC0DE_0000 + 32'(p), "all four");
        c_burst(4'b0110, 4'b0000, 32'h0);
        c_expect(1, 1, 32'hC0DE_0001, "rr p1 first");
        c_expect(2, 2, 32'hC0DE_0002, "rr p2 second");
        c_burst(4'b1010, 4'b0000, 32'h0);
        c_expect(3, 1, 32'hC0DE_0003, "rr p3 first");
        c_expect(1, 2, 32'hC0DE_0001, "rr wrap p1");
        c_burst(4'b1100, 4'b0100, 32'h3000_0200);
        c_expect(2, 1, 32'h0, "raw write");
        c_expect(3, 2, 32'h5A5A_5A5A, "raw read");

        // Write granted, then reset lands while the response is still being delayed.
        @(posedge clock); #1;
        drive(3, 0, 1'b1, 1'b1, 32'h3000_0004, 32'hCAFE_F00D, 4'hF);
        @(posedge clock); #1;
        drive(3, 0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("delay busy", 32'(d_req_ready), 32'h0);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("reset ready", 32'(d_req_ready), 32'h1);
        chk("reset no resp", 32'(d_resp_valid), 32'h0);
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 12; k++) begin
                @(posedge clock); #1;
                if (d_resp_valid[0]) seen++;
            end
            chk("dropped resp", 32'(seen), 32'd0);
        end
        do_access(3, 0, 1'b0, 32'h3000_0004, 32'h0, 4'h0, 6, 32'hCAFE_F00D, 1'b0, "lat5 rd kept");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
